// File: rtl/ex_stage_pkg.sv
// Shared widths, stall encoding, local func codes and ALU op bit positions for the EX stage.
package ex_stage_pkg;

    localparam int ID_TO_EX_WD   = 159;
    localparam int EX_TO_MEM_WD  = 76;
    localparam int STALL_WD      = 6;
    localparam int DIV_STEPS_DEF = 32;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [5:0] FUNC_DIV  = 6'b011010;
    localparam logic [5:0] FUNC_DIVU = 6'b011011;
    localparam logic [5:0] FUNC_MFHI = 6'b010000;
    localparam logic [5:0] FUNC_MFLO = 6'b010010;
    localparam logic [5:0] FUNC_MTHI = 6'b010001;
    localparam logic [5:0] FUNC_MTLO = 6'b010011;

    // bit positions inside the one-hot alu_op field
    localparam int OP_ADD  = 11;
    localparam int OP_SUB  = 10;
    localparam int OP_SLT  = 9;
    localparam int OP_SLTU = 8;
    localparam int OP_AND  = 7;
    localparam int OP_NOR  = 6;
    localparam int OP_OR   = 5;
    localparam int OP_XOR  = 4;
    localparam int OP_SLL  = 3;
    localparam int OP_SRL  = 2;
    localparam int OP_SRA  = 1;
    localparam int OP_LUI  = 0;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/ex_stage_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, signs applied on the way out.
//
// state | meaning
// IDLE  | waiting for a divide to appear in EX
// BUSY  | restoring steps in progress, cnt counts down to terminal 0
// DONE  | quo/rem valid; held until the divide leaves EX (ack)
module div_iter
    import ex_stage_pkg::*;
#(
    parameter int STEPS = DIV_STEPS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        ack,
    input  logic        signed_en,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] quo,
    output logic [31:0] rem
);

    localparam int CNT_W = $clog2(STEPS);

    div_state_e state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [31:0] quo_r, rem_r, div_r, a_abs, b_abs;
    logic        q_neg, r_neg, step_ge;
    logic [32:0] rem_shift, rem_diff;

    assign a_abs     = (signed_en && a[31]) ? (~a + 32'd1) : a;
    assign b_abs     = (signed_en && b[31]) ? (~b + 32'd1) : b;
    assign rem_shift = {rem_r, quo_r[31]};
    assign rem_diff  = rem_shift - {1'b0, div_r};
    assign step_ge   = (rem_shift >= {1'b0, div_r});

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= DIV_IDLE;
        else      state <= state_nx;
    end

    // next-state: start -> 32 steps -> hold result until acknowledged
    always_comb begin
        state_nx = state;
        case (state)
            DIV_IDLE: if (start)      state_nx = DIV_BUSY;
            DIV_BUSY: if (cnt == '0)  state_nx = DIV_DONE;
            DIV_DONE: if (ack)        state_nx = DIV_IDLE;
            default:                  state_nx = DIV_IDLE;
        endcase
    end

    // operand latch and one restoring step per BUSY cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            quo_r <= '0;
            rem_r <= '0;
            div_r <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: if (start) begin
                    quo_r <= a_abs;
                    rem_r <= '0;
                    div_r <= b_abs;
                    q_neg <= signed_en && (a[31] ^ b[31]);
                    r_neg <= signed_en && a[31];
                    cnt   <= CNT_W'(STEPS - 1);
                end
                DIV_BUSY: begin
                    quo_r <= {quo_r[30:0], step_ge};
                    rem_r <= step_ge ? rem_diff[31:0] : rem_shift[31:0];
                    cnt   <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == DIV_BUSY);
    assign done = (state == DIV_DONE);
    assign quo  = q_neg ? (~quo_r + 32'd1) : quo_r;
    assign rem  = r_neg ? (~rem_r + 32'd1) : rem_r;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, ALU, data SRAM request, forwarding taps, HI/LO and divider.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DIV_STEPS = DIV_STEPS_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata,
    output logic                    ex_wreg,
    output logic [4:0]              ex_waddr,
    output logic [31:0]             ex_wdata,
    output logic                    ex_opl,
    output logic                    stallreq_for_ex
);

    logic [ID_TO_EX_WD-1:0] bus_r;
    logic [31:0] pc, inst, rdata1, rdata2;
    logic [11:0] alu_op;
    logic [2:0]  src1_sel;
    logic [3:0]  src2_sel, ram_wen;
    logic        ram_en, rf_we, sel_rf_res;
    logic [4:0]  rf_waddr;

    // ID/EX register: bubble when EX stops but MEM runs, load when EX runs, else hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                       bus_r <= '0;
        else if (stall[2] == STOP && stall[3] == NO_STOP) bus_r <= '0;
        else if (stall[2] == NO_STOP)                   bus_r <= id_to_ex_bus;
    end

    assign {pc, inst, alu_op, src1_sel, src2_sel, ram_en, ram_wen,
            rf_we, rf_waddr, sel_rf_res, rdata1, rdata2} = bus_r;

    logic is_special, inst_div, inst_divu, inst_mfhi, inst_mflo, inst_mthi, inst_mtlo;
    logic div_in_ex, leave_ex, mf_op;

    assign is_special = (inst[31:26] == 6'd0);
    assign inst_div   = is_special && (inst[5:0] == FUNC_DIV);
    assign inst_divu  = is_special && (inst[5:0] == FUNC_DIVU);
    assign inst_mfhi  = is_special && (inst[5:0] == FUNC_MFHI);
    assign inst_mflo  = is_special && (inst[5:0] == FUNC_MFLO);
    assign inst_mthi  = is_special && (inst[5:0] == FUNC_MTHI);
    assign inst_mtlo  = is_special && (inst[5:0] == FUNC_MTLO);
    assign div_in_ex  = inst_div || inst_divu;
    assign leave_ex   = (stall[2] == NO_STOP);
    assign mf_op      = inst_mfhi || inst_mflo;

    logic [31:0] imm_sext, src1, src2, alu_res, ex_result;
    logic [4:0]  shamt;

    assign imm_sext = sext16(inst[15:0]);
    assign src1 = ({32{src1_sel[0]}} & rdata1)
                | ({32{src1_sel[1]}} & pc)
                | ({32{src1_sel[2]}} & {27'd0, inst[10:6]});
    assign src2 = ({32{src2_sel[0]}} & rdata2)
                | ({32{src2_sel[1]}} & imm_sext)
                | ({32{src2_sel[2]}} & 32'd8)
                | ({32{src2_sel[3]}} & {16'd0, inst[15:0]});
    assign shamt = src1[4:0];

    // one-hot ALU: OR of the selected result terms
    always_comb begin
        alu_res = '0;
        if (alu_op[OP_ADD])  alu_res = alu_res | (src1 + src2);
        if (alu_op[OP_SUB])  alu_res = alu_res | (src1 - src2);
        if (alu_op[OP_SLT])  alu_res = alu_res | {31'd0, ($signed(src1) < $signed(src2))};
        if (alu_op[OP_SLTU]) alu_res = alu_res | {31'd0, (src1 < src2)};
        if (alu_op[OP_AND])  alu_res = alu_res | (src1 & src2);
        if (alu_op[OP_NOR])  alu_res = alu_res | ~(src1 | src2);
        if (alu_op[OP_OR])   alu_res = alu_res | (src1 | src2);
        if (alu_op[OP_XOR])  alu_res = alu_res | (src1 ^ src2);
        if (alu_op[OP_SLL])  alu_res = alu_res | (src2 << shamt);
        if (alu_op[OP_SRL])  alu_res = alu_res | (src2 >> shamt);
        if (alu_op[OP_SRA])  alu_res = alu_res | $unsigned($signed(src2) >>> shamt);
        if (alu_op[OP_LUI])  alu_res = alu_res | {src2[15:0], 16'd0};
    end

    logic        div_busy, div_done;
    logic [31:0] div_quo, div_rem, hi, lo;

    div_iter #(.STEPS(DIV_STEPS)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_in_ex && !div_busy && !div_done),
        .ack       (leave_ex),
        .signed_en (inst_div),
        .a         (rdata1),
        .b         (rdata2),
        .busy      (div_busy),
        .done      (div_done),
        .quo       (div_quo),
        .rem       (div_rem)
    );

    // HI/LO: divide result while DONE (repeatable if held; skipped for zero divisor), moves on leaving EX
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else if (div_done && rdata2 != 32'd0) begin
            lo <= div_quo;
            hi <= div_rem;
        end else if (leave_ex && inst_mthi) begin
            hi <= rdata1;
        end else if (leave_ex && inst_mtlo) begin
            lo <= rdata1;
        end
    end

    logic       rf_we_eff;
    logic [4:0] waddr_eff;

    assign ex_result = inst_mfhi ? hi : (inst_mflo ? lo : alu_res);
    assign rf_we_eff = rf_we || mf_op;
    assign waddr_eff = mf_op ? inst[15:11] : rf_waddr;

    assign stallreq_for_ex = div_in_ex && !div_done;

    assign data_sram_en    = ram_en;
    assign data_sram_wen   = ram_wen;
    assign data_sram_addr  = rdata1 + imm_sext;
    assign data_sram_wdata = rdata2;

    assign ex_wreg  = rf_we_eff;
    assign ex_waddr = waddr_eff;
    assign ex_wdata = ex_result;
    assign ex_opl   = sel_rf_res;

    assign ex_to_mem_bus = {pc, ram_en, ram_wen, sel_rf_res, rf_we_eff, waddr_eff, ex_result};

    // rs/rt register indices are consumed in ID; only their read data arrives here
    logic unused_bits;
    assign unused_bits = ^{inst[25:16], stall[5:4], stall[1:0]};

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage; the bench plays the pipeline controller on the stall vector.
module tb_ex_stage;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [5:0]   stall;
    logic [5:0]   stall_force = 6'd0;
    logic [158:0] id_to_ex_bus = '0;
    logic [75:0]  ex_to_mem_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr, data_sram_wdata;
    logic         ex_wreg;
    logic [4:0]   ex_waddr;
    logic [31:0]  ex_wdata;
    logic         ex_opl, stallreq_for_ex;

    int passed = 0;
    int total  = 0;

    localparam logic [11:0] A_ADD = 12'h800, A_SUB = 12'h400, A_SLT = 12'h200, A_SLTU = 12'h100,
                            A_AND = 12'h080, A_NOR = 12'h040, A_OR  = 12'h020, A_XOR  = 12'h010,
                            A_SLL = 12'h008, A_SRL = 12'h004, A_SRA = 12'h002, A_LUI  = 12'h001;

    ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .id_to_ex_bus    (id_to_ex_bus),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .ex_wreg         (ex_wreg),
        .ex_waddr        (ex_waddr),
        .ex_wdata        (ex_wdata),
        .ex_opl          (ex_opl),
        .stallreq_for_ex (stallreq_for_ex)
    );

    always #5 clk = ~clk;

    // controller: divider busy holds stages 0..3 of the stall vector
    assign stall = stallreq_for_ex ? 6'b001111 : stall_force;

    function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sa, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sa, fn};
    endfunction

    function automatic logic [158:0] mk(input logic [31:0] pc, inst, input logic [11:0] op,
                                        input logic [2:0] s1, input logic [3:0] s2,
                                        input logic ren, input logic [3:0] wen, input logic we,
                                        input logic [4:0] wa, input logic sel,
                                        input logic [31:0] r1, r2);
        return {pc, inst, op, s1, s2, ren, wen, we, wa, sel, r1, r2};
    endfunction

    task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic [158:0] b);
        @(negedge clk);
        id_to_ex_bus = b;
        @(posedge clk);
        #1;
    endtask

    task automatic alu_chk(input string tag, input logic [31:0] inst, input logic [11:0] op,
                           input logic [2:0] s1, input logic [3:0] s2,
                           input logic [31:0] r1, r2, pc, exp);
        drive(mk(pc, inst, op, s1, s2, 1'b0, 4'd0, 1'b1, 5'd7, 1'b0, r1, r2));
        chk(tag, 76'(ex_result_w()), 76'(exp));
    endtask

    function automatic logic [31:0] ex_result_w();
        return ex_to_mem_bus[31:0];
    endfunction

    // DIV just entered EX; count cycles stallreq stays high, bounded
    task automatic count_div(input string tag);
        int n = 0;
        while (stallreq_for_ex && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk(tag, 76'(n), 76'd33);
    endtask

    function automatic logic [158:0] div_bus(input logic [5:0] fn, input logic [31:0] r1, r2);
        return mk(32'h200, rtype(5'd8, 5'd9, 5'd0, 5'd0, fn), 12'd0, 3'b001, 4'b0001,
                  1'b0, 4'd0, 1'b0, 5'd0, 1'b0, r1, r2);
    endfunction

    function automatic logic [158:0] mf_bus(input logic [5:0] fn);
        return mk(32'h300, rtype(5'd0, 5'd0, 5'd12, 5'd0, fn), 12'd0, 3'b000, 4'b0000,
                  1'b0, 4'd0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    endfunction

    // full divide: issue, count stall, then read LO and HI back through MFLO/MFHI
    task automatic div_chk(input string tag, input logic [5:0] fn, input logic [31:0] r1, r2,
                           input logic [31:0] exp_lo, exp_hi);
        drive(div_bus(fn, r1, r2));
        id_to_ex_bus = mf_bus(6'b010010);
        count_div({tag, "_stall"});
        @(posedge clk);
        #1;
        chk({tag, "_lo"}, 76'(ex_result_w()), 76'(exp_lo));
        drive(mf_bus(6'b010000));
        chk({tag, "_hi"}, 76'(ex_result_w()), 76'(exp_hi));
    endtask

    initial begin
        #12;
        chk("rst_bus", ex_to_mem_bus, 76'd0);
        chk("rst_stallreq", 76'(stallreq_for_ex), 76'd0);
        chk("rst_sram_en", 76'(data_sram_en), 76'd0);
        @(negedge clk);
        rst = 1'b1;

        // ADDU $3,$1,$2 : 5 + 0xFFFFFFFF wraps to 4
        drive(mk(32'h400, rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'b100001), A_ADD, 3'b001, 4'b0001,
                 1'b0, 4'd0, 1'b1, 5'd3, 1'b0, 32'd5, 32'hFFFF_FFFF));
        chk("addu_bus", ex_to_mem_bus, {32'h400, 1'b0, 4'b0, 1'b0, 1'b1, 5'd3, 32'd4});
        chk("addu_wdata", 76'(ex_wdata), 76'd4);
        chk("addu_wreg", 76'(ex_wreg), 76'd1);
        chk("addu_waddr", 76'(ex_waddr), 76'd3);
        chk("addu_stallreq", 76'(stallreq_for_ex), 76'd0);

        alu_chk("subu", 32'd0, A_SUB, 3'b001, 4'b0001, 32'd3, 32'd5, 32'd0, 32'hFFFF_FFFE);
        alu_chk("slt", 32'd0, A_SLT, 3'b001, 4'b0001, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1);
        alu_chk("sltu", 32'd0, A_SLTU, 3'b001, 4'b0001, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
        alu_chk("and", 32'd0, A_AND, 3'b001, 4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 32'h0000_F000);
        alu_chk("nor", 32'd0, A_NOR, 3'b001, 4'b0001, 32'h0F0F_0000, 32'h00F0_0000, 32'd0, 32'hF000_FFFF);
        alu_chk("xor", 32'd0, A_XOR, 3'b001, 4'b0001, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0, 32'hF0F0_F0F0);
        alu_chk("sll_sa", rtype(5'd0, 5'd2, 5'd7, 5'd4, 6'b000000), A_SLL, 3'b100, 4'b0001,
                32'hFFFF_FFFF, 32'd1, 32'd0, 32'h0000_0010);
        alu_chk("sllv", 32'd0, A_SLL, 3'b001, 4'b0001, 32'h0000_0023, 32'd1, 32'd0, 32'd8);
        alu_chk("sra", rtype(5'd0, 5'd2, 5'd7, 5'd4, 6'b000011), A_SRA, 3'b100, 4'b0001,
                32'd0, 32'h8000_0000, 32'd0, 32'hF800_0000);
        alu_chk("srl", rtype(5'd0, 5'd2, 5'd7, 5'd4, 6'b000010), A_SRL, 3'b100, 4'b0001,
                32'd0, 32'h8000_0000, 32'd0, 32'h0800_0000);
        alu_chk("lui", {6'b001111, 5'd0, 5'd7, 16'h1234}, A_LUI, 3'b001, 4'b1000,
                32'hDEAD_BEEF, 32'd0, 32'd0, 32'h1234_0000);
        alu_chk("ori_zext", {6'b001101, 5'd1, 5'd7, 16'h800F}, A_OR, 3'b001, 4'b1000,
                32'h0000_00F0, 32'd0, 32'd0, 32'h0000_80FF);
        alu_chk("addiu_sext", {6'b001001, 5'd1, 5'd7, 16'hFFFF}, A_ADD, 3'b001, 4'b0010,
                32'h0000_0010, 32'd0, 32'd0, 32'h0000_000F);
        alu_chk("pc_plus8", 32'd0, A_ADD, 3'b010, 4'b0100, 32'd0, 32'd0, 32'h0000_0100, 32'h0000_0108);

        // LW $5,-4($4) with base 0x1000
        drive(mk(32'h500, {6'b100011, 5'd4, 5'd5, 16'hFFFC}, A_ADD, 3'b001, 4'b0010,
                 1'b1, 4'b0000, 1'b1, 5'd5, 1'b1, 32'h0000_1000, 32'd0));
        chk("lw_en", 76'(data_sram_en), 76'd1);
        chk("lw_wen", 76'(data_sram_wen), 76'd0);
        chk("lw_addr", 76'(data_sram_addr), 76'h0FFC);
        chk("lw_opl", 76'(ex_opl), 76'd1);
        chk("lw_waddr", 76'(ex_waddr), 76'd5);

        // stall[2]=Stop, stall[3]=Stop: hold the load
        @(negedge clk);
        stall_force = 6'b001100;
        @(posedge clk);
        #1;
        chk("hold_en", 76'(data_sram_en), 76'd1);

        // stall[2]=Stop, stall[3]=NoStop: bubble
        @(negedge clk);
        stall_force = 6'b000100;
        @(posedge clk);
        #1;
        chk("bubble_wreg", 76'(ex_wreg), 76'd0);
        chk("bubble_en", 76'(data_sram_en), 76'd0);
        chk("bubble_bus", ex_to_mem_bus, 76'd0);
        @(negedge clk);
        stall_force = 6'd0;

        // SW $6,8($4)
        drive(mk(32'h600, {6'b101011, 5'd4, 5'd6, 16'h0008}, A_ADD, 3'b001, 4'b0010,
                 1'b1, 4'b1111, 1'b0, 5'd0, 1'b0, 32'h0000_2000, 32'hDEAD_BEEF));
        chk("sw_wen", 76'(data_sram_wen), 76'hF);
        chk("sw_wdata", 76'(data_sram_wdata), 76'hDEAD_BEEF);
        chk("sw_addr", 76'(data_sram_addr), 76'h2008);
        chk("sw_wreg", 76'(ex_wreg), 76'd0);

        // MFLO forwarding fields are forced
        drive(mf_bus(6'b010010));
        chk("mflo_wreg", 76'(ex_wreg), 76'd1);
        chk("mflo_waddr", 76'(ex_waddr), 76'd12);

        // MTHI then MFHI
        drive(mk(32'h700, rtype(5'd10, 5'd0, 5'd0, 5'd0, 6'b010001), 12'd0, 3'b001, 4'b0001,
                 1'b0, 4'd0, 1'b0, 5'd0, 1'b0, 32'h1234_5678, 32'd0));
        drive(mf_bus(6'b010000));
        chk("mthi_mfhi", 76'(ex_result_w()), 76'h1234_5678);

        div_chk("div_m7_2", 6'b011010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        div_chk("divu_by0", 6'b011011, 32'd100, 32'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        div_chk("divu_big", 6'b011011, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'h0000_000F);
        div_chk("div_min", 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        div_chk("div_m7_m2", 6'b011010, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);

        // back-to-back: second divide starts from IDLE right after the first leaves
        drive(div_bus(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF));
        id_to_ex_bus = div_bus(6'b011011, 32'd100, 32'd7);
        count_div("b2b_first");
        @(posedge clk);
        #1;
        id_to_ex_bus = mf_bus(6'b010010);
        count_div("b2b_second");
        @(posedge clk);
        #1;
        chk("b2b_lo", 76'(ex_result_w()), 76'd14);
        drive(mf_bus(6'b010000));
        chk("b2b_hi", 76'(ex_result_w()), 76'd2);

        // reset at BUSY cycle 10
        drive(div_bus(6'b011010, 32'hFFFF_FFF9, 32'd2));
        id_to_ex_bus = '0;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        #1;
        chk("midrst_stallreq", 76'(stallreq_for_ex), 76'd0);
        chk("midrst_bus", ex_to_mem_bus, 76'd0);
        chk("midrst_wreg", 76'(ex_wreg), 76'd0);
        @(negedge clk);
        id_to_ex_bus = mf_bus(6'b010000);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_hi", 76'(ex_result_w()), 76'd0);
        drive(mf_bus(6'b010010));
        chk("midrst_lo", 76'(ex_result_w()), 76'd0);
        div_chk("reissue", 6'b011010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
